// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one anode per dwell slot with a
// leading guard gap, hex decode, LZ suppression, blanking, PWM dimming.
module disp_scan_ctrl #(
    parameter int unsigned FREQ_HZ        = 27_000_000,
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned DWELL_US       = 8000,
    parameter int unsigned GUARD_CYC      = 270,
    parameter bit          ACTIVE_LOW_AN  = 1'b0,
    parameter bit          ACTIVE_LOW_SEG = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [4*DIGITS-1:0]         digits,
    input  logic [DIGITS-1:0]           dp,
    input  logic [DIGITS-1:0]           blank,
    input  logic                        lz_en,
    input  logic [3:0]                  bright,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg,
    output logic                        seg_dp,
    output logic [$clog2(DIGITS)-1:0]   digit_idx,
    output logic                        frame_tick
);

    localparam int unsigned DWELL_CYC = FREQ_HZ / 1_000_000 * DWELL_US;
    localparam int unsigned ON_CYC    = DWELL_CYC - GUARD_CYC;
    localparam int unsigned CW        = $clog2(DWELL_CYC);
    localparam int unsigned IW        = $clog2(DIGITS);

    localparam logic [CW-1:0]     GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0]     ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{ACTIVE_LOW_AN}};
    localparam logic [6:0]        SEG_OFF    = {7{ACTIVE_LOW_SEG}};

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ON
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          pwm_q, pwm_d;

    logic [4*DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic                sh_lz_q, sh_lz_d;
    logic [3:0]          sh_bright_q, sh_bright_d;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                seg_dp_q, seg_dp_d;
    logic                tick_q, tick_d;

    logic                load;
    logic [DIGITS-1:0]   supp;
    logic                zero_above;
    logic [3:0]          cur_nib;
    logic                lit;
    logic                pwm_on;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b0111111;
            4'h1:    g = 7'b0000110;
            4'h2:    g = 7'b1011011;
            4'h3:    g = 7'b1001111;
            4'h4:    g = 7'b1100110;
            4'h5:    g = 7'b1101101;
            4'h6:    g = 7'b1111101;
            4'h7:    g = 7'b0000111;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1101111;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b1111100;
            4'hC:    g = 7'b0111001;
            4'hD:    g = 7'b1011110;
            4'hE:    g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        return g;
    endfunction

    // Slot sequencing; shadows reload on every entry to GUARD of digit 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pwm_d       = pwm_q + 4'd1;
        tick_d      = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        load   = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tick_d  = 1'b0;
            load    = 1'b0;
        end

        sh_digits_d = load ? digits : sh_digits_q;
        sh_dp_d     = load ? dp     : sh_dp_q;
        sh_blank_d  = load ? blank  : sh_blank_q;
        sh_lz_d     = load ? lz_en  : sh_lz_q;
        sh_bright_d = load ? bright : sh_bright_q;
    end

    // Drives are computed from next-state values so every output register
    // lines up with the state it belongs to on the same edge.
    always_comb begin
        supp       = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            int unsigned j;
            j          = DIGITS - 1 - k;
            zero_above = zero_above & (sh_digits_d[4*j +: 4] == 4'h0);
            supp[j]    = sh_lz_d & (j != 0) & zero_above;
        end

        cur_nib  = sh_digits_d[{idx_d, 2'b00} +: 4];
        lit      = (state_d == ON) && !sh_blank_d[idx_d] && !supp[idx_d];
        pwm_on   = (pwm_d <= sh_bright_d);

        an_d     = lit ? (DIGITS'(1) << idx_d) : '0;
        seg_d    = (lit && pwm_on) ? glyph(cur_nib) : '0;
        seg_dp_d = lit && pwm_on && sh_dp_d[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            sh_lz_q     <= 1'b0;
            sh_bright_q <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            seg_dp_q    <= ACTIVE_LOW_SEG;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            sh_lz_q     <= sh_lz_d;
            sh_bright_q <= sh_bright_d;
            an_q        <= an_d ^ AN_OFF;
            seg_q       <= seg_d ^ SEG_OFF;
            seg_dp_q    <= seg_dp_d ^ ACTIVE_LOW_SEG;
            tick_q      <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: active-high and active-low instances checked
// every cycle against a frame-time reference model, plus directed checks.
module tb_disp_scan_ctrl;

    localparam int unsigned FRAME = 80;
    localparam int unsigned DWELL = 20;
    localparam int unsigned GUARD = 2;
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  bright;

    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [1:0]  idx_a, idx_b;
    logic        tick_a, tick_b;
    logic [14:0] obs_a, obs_b, exp_a, exp_b;

    int checks = 0;
    int errors = 0;

    disp_scan_ctrl #(
        .FREQ_HZ(1_000_000), .DIGITS(4), .DWELL_US(20), .GUARD_CYC(2),
        .ACTIVE_LOW_AN(1'b0), .ACTIVE_LOW_SEG(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
        .blank(blank), .lz_en(lz_en), .bright(bright), .an(an_a),
        .seg(seg_a), .seg_dp(dp_a), .digit_idx(idx_a), .frame_tick(tick_a)
    );

    disp_scan_ctrl #(
        .FREQ_HZ(1_000_000), .DIGITS(4), .DWELL_US(20), .GUARD_CYC(2),
        .ACTIVE_LOW_AN(1'b1), .ACTIVE_LOW_SEG(1'b1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
        .blank(blank), .lz_en(lz_en), .bright(bright), .an(an_b),
        .seg(seg_b), .seg_dp(dp_b), .digit_idx(idx_b), .frame_tick(tick_b)
    );

    assign obs_a = {an_a, seg_a, dp_a, idx_a, tick_a};
    assign obs_b = {an_b, seg_b, dp_b, idx_b, tick_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: time since reset (PWM phase) and time since enable
    // (frame position); the displayed frame is a snapshot taken at its start.
    int unsigned pwm_t;
    int unsigned run_t;
    bit          running;
    logic [15:0] s_digits;
    logic [3:0]  s_dp, s_blank, s_bright;
    logic        s_lz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_t    <= 0;
            run_t    <= 0;
            running  <= 1'b0;
            s_digits <= '0;
            s_dp     <= '0;
            s_blank  <= '0;
            s_bright <= '0;
            s_lz     <= 1'b0;
        end else begin
            pwm_t <= pwm_t + 1;
            if (!en) begin
                running <= 1'b0;
                run_t   <= 0;
            end else begin
                running <= 1'b1;
                run_t   <= running ? run_t + 1 : 0;
                if (!running || ((run_t + 1) % FRAME) == 0) begin
                    s_digits <= digits;
                    s_dp     <= dp;
                    s_blank  <= blank;
                    s_bright <= bright;
                    s_lz     <= lz_en;
                end
            end
        end
    end

    function automatic logic [14:0] model_out(input bit inv);
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [1:0]  e_idx;
        logic        e_tick;
        int unsigned slot;
        int unsigned pos;
        logic [15:0] rest;
        logic        lit;
        e_an = '0; e_seg = '0; e_dp = 1'b0; e_idx = '0; e_tick = 1'b0;
        if (running) begin
            slot   = (run_t % FRAME) / DWELL;
            pos    = run_t % DWELL;
            e_idx  = 2'(slot);
            e_tick = (run_t != 0) && ((run_t % FRAME) == 0);
            rest   = s_digits >> (4 * slot);
            lit    = (pos >= GUARD) && !s_blank[slot] &&
                     !(s_lz && slot != 0 && rest == 16'h0);
            if (lit) begin
                e_an = 4'(1 << slot);
                if ((pwm_t % 16) <= s_bright) begin
                    e_seg = GLYPH[rest[3:0]];
                    e_dp  = s_dp[slot];
                end
            end
        end
        if (inv) begin
            e_an = ~e_an; e_seg = ~e_seg; e_dp = ~e_dp;
        end
        return {e_an, e_seg, e_dp, e_idx, e_tick};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; digits = '0; dp = '0; blank = '0;
        lz_en = 1'b0; bright = '0;
        repeat (3) @(negedge clk);
        checks++; if (an_a !== 4'b0000) begin errors++; $display("FAIL reset_an got=%b exp=0000", an_a); end
        checks++; if (seg_a !== 7'h00) begin errors++; $display("FAIL reset_seg got=%h exp=00", seg_a); end
        checks++; if (dp_a !== 1'b0) begin errors++; $display("FAIL reset_dp got=%b exp=0", dp_a); end
        checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
        checks++; if (tick_a !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick_a); end
        checks++; if (an_b !== 4'b1111) begin errors++; $display("FAIL reset_an_inv got=%b exp=1111", an_b); end
        checks++; if (seg_b !== 7'h7F) begin errors++; $display("FAIL reset_seg_inv got=%h exp=7f", seg_b); end
        checks++; if (dp_b !== 1'b1) begin errors++; $display("FAIL reset_dp_inv got=%b exp=1", dp_b); end
    endtask

    task automatic test_scan();
        int ticks = 0;
        int d0_on = 0;
        en = 1'b1; digits = 16'h1234; bright = 4'd15; rst_n = 1'b1;
        for (int c = 0; c < 170; c++) begin
            @(negedge clk);
            exp_a = model_out(1'b0); exp_b = model_out(1'b1);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL scan_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL scan_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
            if (tick_a) ticks++;
            if (run_t < FRAME && an_a == 4'b0001) d0_on++;
            if (run_t == 1) begin
                checks++; if (an_a !== 4'b0000) begin errors++; $display("FAIL scan_guard got=%b exp=0000", an_a); end
            end
            if (run_t == 2) begin
                checks++; if ({an_a, seg_a} !== {4'b0001, 7'b1100110}) begin errors++; $display("FAIL scan_d0 got=%b/%b exp=0001/1100110", an_a, seg_a); end
                checks++; if ({an_b, seg_b} !== {4'b1110, 7'b0011001}) begin errors++; $display("FAIL scan_d0_inv got=%b/%b exp=1110/0011001", an_b, seg_b); end
            end
            if (run_t == 22) begin
                checks++; if ({an_a, seg_a} !== {4'b0010, 7'b1001111}) begin errors++; $display("FAIL scan_d1 got=%b/%b exp=0010/1001111", an_a, seg_a); end
            end
            if (run_t == 80 || run_t == 160) begin
                checks++; if (tick_a !== 1'b1) begin errors++; $display("FAIL scan_tick t=%0d got=%b exp=1", run_t, tick_a); end
            end
        end
        checks++; if (ticks != 2) begin errors++; $display("FAIL scan_tick_count got=%0d exp=2", ticks); end
        checks++; if (d0_on != 18) begin errors++; $display("FAIL scan_on_len got=%0d exp=18", d0_on); end
    endtask

    task automatic test_tear();
        bit wrapped = 1'b0;
        int unsigned f;
        for (int c = 0; c < 200; c++) begin
            if ((run_t % FRAME) == 25) break;
            @(negedge clk);
        end
        checks++; if ((run_t % FRAME) != 25) begin errors++; $display("FAIL tear_wait got=%0d exp=25", run_t % FRAME); end
        digits = 16'h9999;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            f = run_t % FRAME;
            if (f == 0) wrapped = 1'b1;
            exp_a = model_out(1'b0); exp_b = model_out(1'b1);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL tear_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL tear_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
            if (!wrapped && f == 42) begin
                checks++; if (seg_a !== 7'h5B) begin errors++; $display("FAIL tear_d2 got=%h exp=5b", seg_a); end
            end
            if (!wrapped && f == 62) begin
                checks++; if (seg_a !== 7'h06) begin errors++; $display("FAIL tear_d3 got=%h exp=06", seg_a); end
            end
            if (wrapped && f == 2) begin
                checks++; if (seg_a !== 7'h6F) begin errors++; $display("FAIL tear_next got=%h exp=6f", seg_a); end
            end
        end
    endtask

    task automatic test_lz();
        for (int pass = 0; pass < 2; pass++) begin
            int seen = 0;
            int unsigned f;
            lz_en = 1'b1;
            digits = (pass == 0) ? 16'h0050 : 16'h0000;
            for (int c = 0; c < 160; c++) begin
                @(negedge clk);
                f = run_t % FRAME;
                if (f == 0) seen++;
                exp_a = model_out(1'b0); exp_b = model_out(1'b1);
                checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL lz_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
                checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL lz_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
                if (seen == 1 && (f == 42 || f == 62 || (pass == 1 && f == 22))) begin
                    checks++; if ({an_a, seg_a} !== 11'h0) begin errors++; $display("FAIL lz_dark f=%0d got=%b/%h exp=0000/00", f, an_a, seg_a); end
                end
                if (seen == 1 && pass == 0 && f == 22) begin
                    checks++; if ({an_a, seg_a} !== {4'b0010, 7'b1101101}) begin errors++; $display("FAIL lz_d1 got=%b/%b exp=0010/1101101", an_a, seg_a); end
                end
                if (seen == 1 && f == 2) begin
                    checks++; if ({an_a, seg_a} !== {4'b0001, 7'b0111111}) begin errors++; $display("FAIL lz_d0 got=%b/%b exp=0001/0111111", an_a, seg_a); end
                end
                if (seen == 1 && f == 79) begin
                    checks++; if (idx_a !== 2'd3) begin errors++; $display("FAIL lz_timing got=%0d exp=3", idx_a); end
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_bright();
        int seen = 0;
        int on_cnt = 0;
        int unsigned f;
        int unsigned p;
        bright = 4'd3; digits = 16'($urandom); dp = 4'($urandom); blank = '0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            f = run_t % FRAME;
            p = run_t % DWELL;
            if (f == 0) seen++;
            exp_a = model_out(1'b0); exp_b = model_out(1'b1);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL bright_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL bright_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
            if (seen == 1 && p >= GUARD) begin
                if (p == GUARD) on_cnt = 0;
                if (p < GUARD + 16 && seg_a != 7'h00) on_cnt++;
                if (p == GUARD + 15) begin
                    checks++; if (on_cnt != 4) begin errors++; $display("FAIL bright_duty f=%0d got=%0d exp=4", f, on_cnt); end
                end
                checks++; if (an_a == 4'b0000) begin errors++; $display("FAIL bright_anode f=%0d got=%b exp=nonzero", f, an_a); end
            end
        end
    endtask

    task automatic test_en_drop();
        logic [15:0] fresh;
        bright = 4'd15; blank = '0; lz_en = 1'b0; digits = 16'hABCD;
        for (int c = 0; c < 200; c++) begin
            if ((run_t % FRAME) == 2 * DWELL + GUARD + 4) break;
            @(negedge clk);
        end
        checks++; if ((run_t % FRAME) != 46) begin errors++; $display("FAIL drop_wait got=%0d exp=46", run_t % FRAME); end
        en = 1'b0;
        @(negedge clk);
        checks++; if ({an_a, seg_a, idx_a, tick_a} !== 14'h0) begin errors++; $display("FAIL drop_off got=%b/%h/%0d/%b exp=0000/00/0/0", an_a, seg_a, idx_a, tick_a); end
        checks++; if (an_b !== 4'b1111) begin errors++; $display("FAIL drop_off_inv got=%b exp=1111", an_b); end
        fresh = 16'($urandom);
        digits = fresh;
        en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            exp_a = model_out(1'b0); exp_b = model_out(1'b1);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL drop_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL drop_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
            if (c < 2) begin
                checks++; if (an_a !== 4'b0000) begin errors++; $display("FAIL drop_guard c=%0d got=%b exp=0000", c, an_a); end
            end
            if (c == 2) begin
                checks++; if ({an_a, seg_a} !== {4'b0001, GLYPH[fresh[3:0]]}) begin errors++; $display("FAIL drop_restart got=%b/%h exp=0001/%h", an_a, seg_a, GLYPH[fresh[3:0]]); end
            end
            if (c == 0) begin
                checks++; if (tick_a !== 1'b0) begin errors++; $display("FAIL drop_tick got=%b exp=0", tick_a); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            exp_a = model_out(1'b0); exp_b = model_out(1'b1);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL rand_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL rand_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
            if ($urandom_range(0, 29) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 2) == 0) digits[15:8] = 8'h00;
                dp     = 4'($urandom);
                blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                lz_en  = 1'($urandom);
                bright = 4'($urandom);
            end
            en = ($urandom_range(0, 199) != 0);
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        repeat (27) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({an_a, seg_a, dp_a, idx_a, tick_a} !== 15'h0) begin errors++; $display("FAIL areset got=%h exp=0000", {an_a, seg_a, dp_a, idx_a, tick_a}); end
        checks++; if ({an_b, seg_b, dp_b} !== 12'hFFF) begin errors++; $display("FAIL areset_inv got=%h exp=fff", {an_b, seg_b, dp_b}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exp_a = model_out(1'b0); exp_b = model_out(1'b1);
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL arst_a t=%0d got=%h exp=%h", run_t, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL arst_b t=%0d got=%h exp=%h", run_t, obs_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_lz();
        test_bright();
        test_en_drop();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Parametrised multiplexed 7-segment display scan controller: drives `DIGITS` common anodes one at a time with a fixed per-digit dwell. It decodes a per-digit hex nibble to segments and adds decimal points, per-digit blanking, leading-zero suppression, inter-digit ghosting guard, 16-level brightness PWM and selectable output polarity. It sits between the value-producing logic and the board display pins, replacing the fixed 3-digit anode rotator.

## Interface
- `FREQ_HZ`, 27_000_000: input clock frequency; must be a multiple of 1_000_000.
- `DIGITS`, 3: number of digits; must be ≥ 2.
- `DWELL_US`, 8000: slot per digit in µs; `DWELL_CYC = FREQ_HZ/1_000_000*DWELL_US` (216_000 at defaults).
- `GUARD_CYC`, 270: anode-off cycles at the start of each slot; must satisfy 1 ≤ `GUARD_CYC` < `DWELL_CYC`.
- `ACTIVE_LOW_AN`, 0: 1 inverts `an`.
- `ACTIVE_LOW_SEG`, 0: 1 inverts `seg` and `seg_dp`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable.
- `digits` in 4*DIGITS: nibble i = value of digit i; digit 0 is least significant.
- `dp` in DIGITS: decimal point per digit.
- `blank` in DIGITS: force digit i dark.
- `lz_en` in 1: leading-zero suppression enable.
- `bright` in 4: brightness level, 0 (1/16 duty) to 15 (full).
- `an` out DIGITS: anode drive, one-hot or all-off.
- `seg` out 7: {g,f,e,d,c,b,a}.
- `seg_dp` out 1: decimal point drive.
- `digit_idx` out $clog2(DIGITS): current slot index.
- `frame_tick` out 1: one-cycle frame-boundary pulse.

## Operation
- Three states: IDLE, GUARD, ON. In each slot, GUARD lasts `GUARD_CYC` cycles, then ON lasts `ON_CYC = DWELL_CYC - GUARD_CYC` cycles. Frame length = `DIGITS*DWELL_CYC`.
- IDLE -> GUARD(digit 0) when `en`=1.
- GUARD -> ON at the end of the guard count. ON -> GUARD(idx+1) at the end of the on count. From the last digit, the transition wraps to digit 0.
- `en`=0 in any state -> IDLE on the next edge. IDLE clears `digit_idx`, the dwell counter and all drives.
- Shadow registers capture `digits`, `dp`, `blank`, `lz_en` and `bright` on every entry to GUARD(digit 0). Displayed data never changes mid-frame (tear-free).
- Decode covers the full hex range 0-F: standard glyphs, with b, d in lower case.
- Leading-zero suppression, when `lz_en`=1: digit i is suppressed if its nibble and every more-significant nibble are 0. Digit 0 is never suppressed.
- A suppressed or `blank` digit keeps its slot timing with anode off, `seg` off and `seg_dp` off.
- ON state: the anode of `digit_idx` is asserted for the whole ON interval.
- Brightness PWM:
  - `seg` and `seg_dp` are driven only while `pwm_cnt` ≤ shadow `bright`.
  - `pwm_cnt` is a free-running 4-bit counter, reset to 0, wrapping 15 -> 0.
- Polarity inversion is applied at the output registers only.

## Timing
- Reset values, with polarity applied:
  - `an` = all off.
  - `seg` = off.
  - `seg_dp` = off.
  - `digit_idx` = 0.
  - `frame_tick` = 0.
  - State = IDLE; counters = 0; shadows = 0.
- `an`, `seg`, `seg_dp`, `digit_idx` and `frame_tick` are registered and update together on the same edge.
- First edge with `en`=1 after IDLE: enters GUARD(0) and loads the shadows. The first anode assertion follows `GUARD_CYC` cycles later.
- Each asserted digit's anode is high for exactly `ON_CYC` consecutive cycles. Between consecutive anodes there are exactly `GUARD_CYC` all-off cycles.
- `frame_tick` is high for the first GUARD(0) cycle of every frame except the first after leaving IDLE.
- `en` falling mid-slot: outputs go off on the next edge and no `frame_tick` is issued. Re-enable restarts at GUARD(0) with a fresh shadow load.
- `rst_n` asserted mid-frame: all outputs take their reset values immediately (asynchronous).

## Test plan
Bench parameters: `FREQ_HZ`=1_000_000, `DWELL_US`=20, `GUARD_CYC`=2, `DIGITS`=4, giving `ON_CYC`=18 and a 80-cycle frame.

- Reset/scan: hold `rst_n` low -> `an`=0000, `seg`=0, `frame_tick`=0.
  - Release with `en`=1, `digits`=16'h1234, `bright`=15, `lz_en`=0.
  - Required: 2 off cycles, then `an`=0001 for 18 cycles with `seg`=7'b1100110 ('4'), then 2 off cycles, then `an`=0010 with `seg`=7'b1001111 ('3').
  - Required: `frame_tick` pulses every 80 cycles from cycle 80 on.
- Tear-free: change `digits` to 16'h9999 during digit 1 -> digits 2 and 3 still show '2' and '1'. Required: '9' appears only from the next frame.
- Leading zeros: `lz_en`=1, `digits`=16'h0050 -> digits 3 and 2 dark with slot timing kept; digit 1 shows '5' (7'b1101101), digit 0 shows '0' (7'b0111111). With `digits`=16'h0000, only digit 0 shows '0'.
- Brightness: `bright`=3 -> during each ON interval, `seg` is active exactly 4 of every 16 cycles, aligned to `pwm_cnt` 0-3, with the anode held on throughout.
- Enable drop: `en`=0 at cycle 5 of digit 2 ON -> next edge: `an`=0000, `digit_idx`=0, no `frame_tick`. Re-enable: 2 guard cycles, then digit 0 shows the newly captured value.
- Polarity: `ACTIVE_LOW_AN`=1, `ACTIVE_LOW_SEG`=1 -> reset gives `an`=1111, `seg`=7'h7F, `seg_dp`=1. Digit 0 ON shows `an`=1110 and the complemented glyph.
